axis_scope_trigger_ctrl: RTL and testbench

Sequencer for the axis oscilloscope capture core.
- Generates its run_flag and trg_flag from a snooped sample stream.
- Watches the core's enable bit (sts_data bit 0) to track frame completion.
- Supports normal, auto and single modes, level/edge trigger with hysteresis, and holdoff between frames.
- Sits between the configuration/status registers and the capture core, on the same sample stream.

---
 rtl/axis_scope_pkg.sv | 28 ++
 rtl/axis_scope_trigger_ctrl_if.sv | 10 +
 rtl/axis_scope_level_cmp.sv | 71 +++++++
 rtl/axis_scope_trigger_ctrl.sv | 168 ++++++++++++++++
 tb/tb_axis_scope_trigger_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_scope_pkg.sv
// Shared types and helpers for the axis scope trigger sequencer.
package axis_scope_pkg;

  // Sequencer states; the encoding is visible in sts_data[2:0].
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ARMED = 3'd3,
    ST_TRIG  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  // Working width for threshold math; covers channels up to 32 bits plus a guard bit.
  localparam int unsigned THR_W = 33;

  // Level plus or minus hysteresis on operands already widened to THR_W, so no wrap.
  function automatic logic signed [THR_W-1:0] lvl_hys(input logic signed [THR_W-1:0] lvl,
                                                      input logic signed [THR_W-1:0] hys,
                                                      input logic                    add);
    return add ? (lvl + hys) : (lvl - hys);
  endfunction

endpackage

// File: rtl/axis_scope_trigger_ctrl_if.sv
// Snooped sample stream (no tready: the capture core owns flow control).
interface axis_scope_trigger_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_scope_level_cmp.sv
// Level comparator with hysteresis on one of two signed channels.
// cross_c_o flags a valid sample at/over the level in the selected direction;
// armed_o is the registered hysteresis-armed bit. A trigger is cross && armed.
module axis_scope_level_cmp
  import axis_scope_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          chn_i,
  input  logic                          pol_i,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] lvl_i,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] hys_i,
  input  logic [AXIS_TDATA_WIDTH-1:0]   tdata_i,
  input  logic                          tvalid_i,
  output logic                          cross_c_o,
  output logic                          armed_o
);

  localparam int unsigned HALF_W = AXIS_TDATA_WIDTH / 2;
  localparam int unsigned EXT_W  = HALF_W + 1;
  localparam int unsigned PAD_W  = THR_W - HALF_W;

  logic [HALF_W-1:0]       smp;
  logic signed [EXT_W-1:0] smp_x;
  logic signed [EXT_W-1:0] lvl_x;
  logic signed [EXT_W-1:0] lo_x;
  logic signed [EXT_W-1:0] hi_x;
  logic signed [THR_W-1:0] lvl_w;
  logic signed [THR_W-1:0] hys_w;
  logic                    armed_q;
  logic                    armed_d;

  // Channel select and sign extension to one guard bit.
  always_comb begin
    smp   = chn_i ? tdata_i[AXIS_TDATA_WIDTH-1:HALF_W] : tdata_i[HALF_W-1:0];
    smp_x = {smp[HALF_W-1], smp};
    lvl_x = {lvl_i[HALF_W-1], lvl_i};
    lvl_w = {{PAD_W{lvl_i[HALF_W-1]}}, lvl_i};
    hys_w = {{PAD_W{1'b0}}, hys_i};
    lo_x  = EXT_W'(lvl_hys(lvl_w, hys_w, 1'b0));
    hi_x  = EXT_W'(lvl_hys(lvl_w, hys_w, 1'b1));
  end

  // Arm on the far side of the hysteresis band; report level crossing.
  always_comb begin
    armed_d   = armed_q;
    cross_c_o = 1'b0;
    if (en_i && tvalid_i) begin
      if (!pol_i) begin
        if (smp_x < lo_x) armed_d = 1'b1;
        cross_c_o = (smp_x >= lvl_x);
      end else begin
        if (smp_x > hi_x) armed_d = 1'b1;
        cross_c_o = (smp_x <= lvl_x);
      end
    end
  end

  // Armed bit register, cleared at the start of every frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) armed_q <= 1'b0;
    else                armed_q <= armed_d;
  end

  assign armed_o = armed_q;

endmodule

// File: rtl/axis_scope_trigger_ctrl.sv
// Trigger sequencer for the axis oscilloscope capture core.
// Optional build macro TRG_EXT_EN adds an external trigger input (trg_ext)
// selectable by src_flag in place of the level comparator.
module axis_scope_trigger_ctrl
  import axis_scope_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32,
  parameter int unsigned FCNT_WIDTH       = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          arm_flag,
  input  logic                          stop_flag,
  input  logic [1:0]                    mode_data,
  input  logic                          pol_flag,
  input  logic                          chn_flag,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] lvl_data,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] hys_data,
  input  logic [CNTR_WIDTH-1:0]         hld_data,
  input  logic [CNTR_WIDTH-1:0]         tmo_data,
`ifdef TRG_EXT_EN
  input  logic                          trg_ext,
  input  logic                          src_flag,
`endif
  input  logic                          scope_enbl,
  axis_scope_trigger_ctrl_if.slave      s_axis,
  output logic                          run_flag,
  output logic                          trg_flag,
  output logic [FCNT_WIDTH+3:0]         sts_data
);

  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  forced_q, forced_d;
  logic                  stop_q, stop_d;
  logic                  run_q, run_d;
  logic                  trg_q, trg_d;
  logic                  lvl_cross_c;
  logic                  lvl_armed;
  logic                  hit_c;
  logic                  single_c;
  logic                  auto_c;
  logic                  hold_done_c;

  axis_scope_level_cmp #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_cmp (
    .clk_i    (aclk),
    .rst_i    (areset),
    .en_i     (state_q == ST_ARMED),
    .clr_i    (state_q == ST_START),
    .chn_i    (chn_flag),
    .pol_i    (pol_flag),
    .lvl_i    (lvl_data),
    .hys_i    (hys_data),
    .tdata_i  (s_axis.tdata),
    .tvalid_i (s_axis.tvalid),
    .cross_c_o(lvl_cross_c),
    .armed_o  (lvl_armed)
  );

`ifdef TRG_EXT_EN
  logic [2:0] ext_q;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge aclk) begin
    if (areset) ext_q <= 3'b000;
    else        ext_q <= {ext_q[1:0], trg_ext};
  end

  assign hit_c = src_flag ? (ext_q[1] & ~ext_q[2]) : (lvl_armed & lvl_cross_c);
`else
  assign hit_c = lvl_armed & lvl_cross_c;
`endif

  // Mode decode; code 3 behaves as single.
  always_comb begin
    single_c = 1'b1;
    auto_c   = (mode_data == MODE_AUTO);
    case (mode_data)
      MODE_NORMAL, MODE_AUTO: single_c = 1'b0;
      default:                single_c = 1'b1;
    endcase
  end

  // Holdoff of zero still spends one cycle in HOLD.
  assign hold_done_c = (hld_data == '0) || (cnt_q >= (hld_data - CNTR_WIDTH'(1)));

  // Next-state and output decode; the hit is acted on in the same cycle so the
  // core sees trg_flag with the sample following the hit sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    forced_d = forced_q;
    stop_d   = stop_q;
    if (state_q != ST_IDLE && stop_flag) stop_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (arm_flag) state_d = ST_START;
      end
      ST_START: begin
        forced_d = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = '0;
        if (scope_enbl) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNTR_WIDTH'(1);
        if (hit_c) begin
          state_d = ST_TRIG;
        end else if ((auto_c && (cnt_q == tmo_data)) || stop_q) begin
          state_d  = ST_TRIG;
          forced_d = 1'b1;
        end
      end
      ST_TRIG: begin
        if (!scope_enbl) begin
          fcnt_d  = fcnt_q + FCNT_WIDTH'(1);
          cnt_d   = '0;
          state_d = (single_c || stop_q) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (stop_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNTR_WIDTH'(1);
          if (hold_done_c) state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_START);
    trg_d = (state_d == ST_TRIG);
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      forced_q <= 1'b0;
      stop_q   <= 1'b0;
      run_q    <= 1'b0;
      trg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      forced_q <= forced_d;
      stop_q   <= stop_d;
      run_q    <= run_d;
      trg_q    <= trg_d;
    end
  end

  assign run_flag = run_q;
  assign trg_flag = trg_q;
  assign sts_data = {fcnt_q, forced_q, state_q};

endmodule

// File: tb/tb_axis_scope_trigger_ctrl.sv
// Directed bench for the axis scope trigger sequencer.
module tb_axis_scope_trigger_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        arm_flag;
  logic        stop_flag;
  logic [1:0]  mode_data;
  logic        pol_flag;
  logic        chn_flag;
  logic [15:0] lvl_data;
  logic [15:0] hys_data;
  logic [31:0] hld_data;
  logic [31:0] tmo_data;
  logic        scope_enbl;
  logic        run_flag;
  logic        trg_flag;
  logic [19:0] sts_data;
`ifdef TRG_EXT_EN
  logic        trg_ext = 1'b0;
  logic        src_flag = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int run_total = 0;

  axis_scope_trigger_ctrl_if #(.DATA_W(32)) s_axis_if ();

  axis_scope_trigger_ctrl dut (
    .aclk      (aclk),
    .areset    (areset),
    .arm_flag  (arm_flag),
    .stop_flag (stop_flag),
    .mode_data (mode_data),
    .pol_flag  (pol_flag),
    .chn_flag  (chn_flag),
    .lvl_data  (lvl_data),
    .hys_data  (hys_data),
    .hld_data  (hld_data),
    .tmo_data  (tmo_data),
`ifdef TRG_EXT_EN
    .trg_ext   (trg_ext),
    .src_flag  (src_flag),
`endif
    .scope_enbl(scope_enbl),
    .s_axis    (s_axis_if),
    .run_flag  (run_flag),
    .trg_flag  (trg_flag),
    .sts_data  (sts_data)
  );

  always #5 aclk = ~aclk;

  // Count cycles with run_flag high, sampled mid-cycle.
  always @(negedge aclk) if (run_flag) run_total++;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Selected channel carries v; the other half holds 500 as a decoy.
  task automatic drive(input int v, input logic vld);
    logic [15:0] s;
    s = 16'(v);
    s_axis_if.tvalid = vld;
    if (chn_flag) s_axis_if.tdata = {s, 16'd500};
    else          s_axis_if.tdata = {16'd500, s};
  endtask

  task automatic do_reset();
    areset = 1'b1; arm_flag = 1'b0; stop_flag = 1'b0; scope_enbl = 1'b0;
    s_axis_if.tvalid = 1'b0; s_axis_if.tdata = 32'd0;
    mode_data = 2'd0; pol_flag = 1'b0; chn_flag = 1'b0;
    lvl_data = 16'd100; hys_data = 16'd10; hld_data = 32'd5; tmo_data = 32'd0;
    tick(); tick();
    areset = 1'b0;
  endtask

  // IDLE -> START -> WAIT -> ARMED with the core enable raised.
  task automatic go_armed();
    arm_flag = 1'b1; tick();
    arm_flag = 1'b0; scope_enbl = 1'b1; tick(); tick();
  endtask

  task automatic test_reset();
    areset = 1'b1; arm_flag = 1'b1; stop_flag = 1'b0; scope_enbl = 1'b0;
    s_axis_if.tvalid = 1'b0; s_axis_if.tdata = 32'd0;
    mode_data = 2'd0; pol_flag = 1'b0; chn_flag = 1'b0;
    lvl_data = 16'd100; hys_data = 16'd10; hld_data = 32'd5; tmo_data = 32'd0;
    tick(); tick();
    checks++; if (run_flag !== 1'b0) begin errors++; $display("FAIL reset_run: got %b exp 0", run_flag); end
    checks++; if (trg_flag !== 1'b0) begin errors++; $display("FAIL reset_trg: got %b exp 0", trg_flag); end
    checks++; if (sts_data !== 20'h0) begin errors++; $display("FAIL reset_sts: got %h exp 00000", sts_data); end
    areset = 1'b0; arm_flag = 1'b0; tick();
    checks++; if (sts_data !== 20'h0) begin errors++; $display("FAIL reset_idle_hold: got %h exp 00000", sts_data); end
  endtask

  task automatic test_normal();
    int base, hit_v, n;
    do_reset();
    base = run_total;
    arm_flag = 1'b1; tick();
    checks++; if (run_flag !== 1'b1) begin errors++; $display("FAIL norm_run: got %b exp 1", run_flag); end
    checks++; if (sts_data !== 20'h1) begin errors++; $display("FAIL norm_start: got %h exp 00001", sts_data); end
    arm_flag = 1'b0; scope_enbl = 1'b1; tick(); tick();
    checks++; if (sts_data !== 20'h3) begin errors++; $display("FAIL norm_armed: got %h exp 00003", sts_data); end
    hit_v = 9999;
    for (int v = -50; v <= 300; v++) begin
      drive(v, 1'b1); tick();
      if (trg_flag === 1'b1) begin hit_v = v; break; end
    end
    checks++; if (hit_v != 100) begin errors++; $display("FAIL norm_hit_sample: got %0d exp 100", hit_v); end
    checks++; if (sts_data !== 20'h4) begin errors++; $display("FAIL norm_trig_sts: got %h exp 00004", sts_data); end
    checks++; if (run_total - base != 1) begin errors++; $display("FAIL norm_run_once: got %0d exp 1", run_total - base); end
    repeat (3) tick();
    checks++; if (trg_flag !== 1'b1) begin errors++; $display("FAIL norm_trg_held: got %b exp 1", trg_flag); end
    scope_enbl = 1'b0; tick();
    checks++; if (sts_data !== 20'h15) begin errors++; $display("FAIL norm_hold_sts: got %h exp 00015", sts_data); end
    checks++; if (trg_flag !== 1'b0) begin errors++; $display("FAIL norm_trg_drop: got %b exp 0", trg_flag); end
    n = 0;
    while (run_flag !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 5) begin errors++; $display("FAIL norm_holdoff: got %0d exp 5", n); end
    checks++; if (sts_data[2:0] !== 3'd1) begin errors++; $display("FAIL norm_rearm_state: got %0d exp 1", sts_data[2:0]); end
    tick();
    checks++; if (run_total - base != 2) begin errors++; $display("FAIL norm_run_pulse: got %0d exp 2", run_total - base); end
  endtask

  task automatic test_hysteresis();
    int seen;
    do_reset();
    chn_flag = 1'b1;
    go_armed();
    seen = 0;
    for (int i = 0; i < 44; i++) begin
      drive(95 + (i % 11), 1'b1); tick();
      if (trg_flag === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL hys_no_trig: got %0d exp 0", seen); end
    checks++; if (sts_data !== 20'h3) begin errors++; $display("FAIL hys_still_armed: got %h exp 00003", sts_data); end
    drive(80, 1'b1); tick();
    checks++; if (trg_flag !== 1'b0) begin errors++; $display("FAIL hys_dip: got %b exp 0", trg_flag); end
    drive(100, 1'b0); tick();
    checks++; if (trg_flag !== 1'b0) begin errors++; $display("FAIL hys_invalid: got %b exp 0", trg_flag); end
    drive(100, 1'b1); tick();
    checks++; if (trg_flag !== 1'b1) begin errors++; $display("FAIL hys_rise: got %b exp 1", trg_flag); end
  endtask

  task automatic test_auto_timeout();
    int n;
    do_reset();
    mode_data = 2'd1; tmo_data = 32'd1000;
    drive(0, 1'b1);
    go_armed();
    n = 0;
    while (trg_flag !== 1'b1 && n < 2000) begin tick(); n++; end
    checks++; if (n != 1001) begin errors++; $display("FAIL auto_latency: got %0d exp 1001", n); end
    checks++; if (sts_data !== 20'hC) begin errors++; $display("FAIL auto_forced: got %h exp 0000c", sts_data); end
    do_reset();
    mode_data = 2'd1; tmo_data = 32'd0;
    drive(0, 1'b1);
    go_armed();
    n = 0;
    while (trg_flag !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL auto_tmo0: got %0d exp 1", n); end
  endtask

  task automatic test_single_falling();
    int base, hit_i;
    real r;
    do_reset();
    mode_data = 2'd2; pol_flag = 1'b1; lvl_data = 16'hFF38; hys_data = 16'd10;
    base = run_total;
    go_armed();
    hit_i = -1;
    for (int i = 0; i < 64; i++) begin
      r = 1000.0 * $sin(6.283185307179586 * i / 64.0);
      drive($rtoi(r), 1'b1); tick();
      if (trg_flag === 1'b1) begin hit_i = i; break; end
    end
    checks++; if (hit_i != 35) begin errors++; $display("FAIL single_hit_idx: got %0d exp 35", hit_i); end
    tick(); tick();
    scope_enbl = 1'b0; tick();
    checks++; if (sts_data !== 20'h10) begin errors++; $display("FAIL single_idle: got %h exp 00010", sts_data); end
    repeat (20) tick();
    checks++; if (run_total - base != 1) begin errors++; $display("FAIL single_one_run: got %0d exp 1", run_total - base); end
  endtask

  task automatic test_stop_and_reset();
    int base;
    do_reset();
    hld_data = 32'd2;
    drive(0, 1'b1);
    base = run_total;
    go_armed();
    repeat (5) tick();
    stop_flag = 1'b1; tick();
    stop_flag = 1'b0;
    checks++; if (sts_data !== 20'h3) begin errors++; $display("FAIL stop_latch_cycle: got %h exp 00003", sts_data); end
    tick();
    checks++; if (trg_flag !== 1'b1) begin errors++; $display("FAIL stop_forced_trg: got %b exp 1", trg_flag); end
    checks++; if (sts_data !== 20'hC) begin errors++; $display("FAIL stop_forced_sts: got %h exp 0000c", sts_data); end
    repeat (3) tick();
    scope_enbl = 1'b0; tick();
    checks++; if (sts_data !== 20'h18) begin errors++; $display("FAIL stop_idle: got %h exp 00018", sts_data); end
    repeat (10) tick();
    checks++; if (run_total - base != 1) begin errors++; $display("FAIL stop_no_rerun: got %0d exp 1", run_total - base); end
    go_armed();
    drive(80, 1'b1); tick();
    drive(100, 1'b1); tick();
    checks++; if (trg_flag !== 1'b1) begin errors++; $display("FAIL rst_pre_trg: got %b exp 1", trg_flag); end
    areset = 1'b1; tick();
    checks++; if ({run_flag, trg_flag, sts_data} !== 22'h0) begin errors++; $display("FAIL rst_in_trig: got %h exp 000000", {run_flag, trg_flag, sts_data}); end
    areset = 1'b0; scope_enbl = 1'b0; tick();
  endtask

  task automatic test_extremes();
    int   xs [5] = '{32667, 32767, 32666, 32766, 32767};
    logic ex [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    lvl_data = 16'h7FFF; hys_data = 16'd100;
    go_armed();
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], 1'b1); tick();
      checks++;
      if (trg_flag !== ex[i]) begin errors++; $display("FAIL ext_step%0d: got %b exp %b", i, trg_flag, ex[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hysteresis();
    test_auto_timeout();
    test_single_falling();
    test_stop_and_reset();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
